// File: rtl/dpa_pkg.sv
// dpa_pkg: definitions shared by dpa_arb and its sub-modules.
//   state_t        - arbiter FSM states (idle / calculate / respond)
//   FLAG_*         - bit positions inside rsp_flags = {cout, negative, overflow, zero}
//   DPA_N_DEFAULT  - default operand width of the shared DPA1 adder
package dpa_pkg;

  localparam int unsigned DPA_N_DEFAULT = 64;

  localparam int unsigned FLAG_ZERO = 0;
  localparam int unsigned FLAG_OVF  = 1;
  localparam int unsigned FLAG_NEG  = 2;
  localparam int unsigned FLAG_COUT = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dpa1.sv
// dpa1: combinational N-bit adder with status flags.
// Ports:
//   a, b       in  N  operands
//   cin        in  1  carry-in
//   signed_en  in  1  enables the two's-complement overflow flag
//   final_sum  out N  a + b + cin, modulo 2^N
//   cout       out 1  carry out of bit N-1
//   negative   out 1  final_sum[N-1]
//   overflow   out 1  signed overflow (forced to 0 when signed_en=0)
//   zero       out 1  final_sum == 0
module dpa1 #(
  parameter int unsigned N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         signed_en,
  output logic [N-1:0] final_sum,
  output logic         cout,
  output logic         negative,
  output logic         overflow,
  output logic         zero
);

  logic [N:0] w_full;

  assign w_full    = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
  assign final_sum = w_full[N-1:0];
  assign cout      = w_full[N];
  assign negative  = w_full[N-1];
  // Same-sign operands producing a result of the other sign.
  assign overflow  = signed_en & (a[N-1] ~^ b[N-1]) & (w_full[N-1] ^ a[N-1]);
  assign zero      = (w_full[N-1:0] == '0);

endmodule

// File: rtl/rr_arb.sv
// rr_arb: round-robin priority selector.
// Ports:
//   req    in  NREQ      request vector
//   ptr    in  clog2     index with highest priority (must be < NREQ)
//   grant  out NREQ      one-hot first set bit of req searching upward
//                        from ptr with wrap-around; zero when req == 0
module rr_arb #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned PW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  logic [NREQ-1:0] w_rot;
  logic [NREQ-1:0] w_grot;
  logic            w_found;

  // Rotate so that bit 0 is the requester at ptr, pick the lowest set bit,
  // then rotate the one-hot result back.
  assign w_rot = NREQ'({req, req} >> ptr);

  always_comb begin
    w_grot  = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_grot[k] = 1'b1;
        w_found   = 1'b1;
      end
    end
  end

  assign grant = NREQ'(({w_grot, w_grot} << ptr) >> NREQ);

endmodule

// File: rtl/dpa_arb.sv
// dpa_arb: round-robin arbiter sharing one DPA1 adder among NREQ requesters.
// One operation per 3 cycles: IDLE (accept) -> CALC (add) -> RESP (hold).
// Optional feature: define DPA_ARB_PERF_EN to add per-requester saturating
// 16-bit grant counters on output perf_cnt.
// Ports:
//   clk, rst    in   clock, synchronous active-high reset
//   req_valid   in   NREQ      request valid per requester
//   req_ready   out  NREQ      one-hot accept strobe (IDLE only)
//   req_a/b     in   NREQ*N    packed operands, requester i at [i*N +: N]
//   req_cin     in   NREQ      carry-in per requester
//   req_signed  in   NREQ      signed_en per requester
//   rsp_valid   out  1         response valid (RESP only)
//   rsp_ready   in   1         response accept
//   rsp_id      out  clog2     owner of the response
//   rsp_sum     out  N         registered sum
//   rsp_flags   out  4         registered {cout, negative, overflow, zero}
//   perf_cnt    out  NREQ*16   grant counters (DPA_ARB_PERF_EN only)
module dpa_arb
  import dpa_pkg::*;
#(
  parameter int unsigned N    = DPA_N_DEFAULT,
  parameter int unsigned NREQ = 4,
  localparam int unsigned PW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*N-1:0]   req_a,
  input  logic [NREQ*N-1:0]   req_b,
  input  logic [NREQ-1:0]     req_cin,
  input  logic [NREQ-1:0]     req_signed,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [PW-1:0]       rsp_id,
  output logic [N-1:0]        rsp_sum,
  output logic [3:0]          rsp_flags
`ifdef DPA_ARB_PERF_EN
  ,
  output logic [NREQ*16-1:0]  perf_cnt
`endif
);

  state_t          r_state;
  state_t          w_next;
  logic [PW-1:0]   r_ptr;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic            r_cin;
  logic            r_sgn;
  logic [PW-1:0]   r_id;

  logic [NREQ-1:0] w_req;
  logic [NREQ-1:0] w_grant;
  logic [PW-1:0]   w_gidx;
  logic            w_xfer;
  logic [N-1:0]    w_sel_a;
  logic [N-1:0]    w_sel_b;
  logic            w_sel_cin;
  logic            w_sel_sgn;

  logic [N-1:0]    w_sum;
  logic            w_cout;
  logic            w_neg;
  logic            w_ovf;
  logic            w_zero;

  // Requests are only visible to the selector while idle and out of reset.
  assign w_req = (r_state == ST_IDLE && !rst) ? req_valid : '0;

  rr_arb #(.NREQ(NREQ)) u_rr_arb (
    .req   (w_req),
    .ptr   (r_ptr),
    .grant (w_grant)
  );

  assign req_ready = w_grant;
  assign w_xfer    = |(req_valid & w_grant);

  always_comb begin
    w_gidx    = '0;
    w_sel_a   = '0;
    w_sel_b   = '0;
    w_sel_cin = 1'b0;
    w_sel_sgn = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_gidx    = PW'(i);
        w_sel_a   = req_a[i*N +: N];
        w_sel_b   = req_b[i*N +: N];
        w_sel_cin = req_cin[i];
        w_sel_sgn = req_signed[i];
      end
    end
  end

  dpa1 #(.N(N)) u_dpa1 (
    .a         (r_a),
    .b         (r_b),
    .cin       (r_cin),
    .signed_en (r_sgn),
    .final_sum (w_sum),
    .cout      (w_cout),
    .negative  (w_neg),
    .overflow  (w_ovf),
    .zero      (w_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_xfer)    w_next = ST_CALC;
      ST_CALC:                w_next = ST_RESP;
      ST_RESP: if (rsp_ready) w_next = ST_IDLE;
      default:                w_next = ST_IDLE;
    endcase
  end

  assign rsp_valid = (r_state == ST_RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_cin     <= 1'b0;
      r_sgn     <= 1'b0;
      r_id      <= '0;
      rsp_sum   <= '0;
      rsp_flags <= '0;
      rsp_id    <= '0;
    end else begin
      if (r_state == ST_IDLE && w_xfer) begin
        r_a   <= w_sel_a;
        r_b   <= w_sel_b;
        r_cin <= w_sel_cin;
        r_sgn <= w_sel_sgn;
        r_id  <= w_gidx;
        r_ptr <= (w_gidx == PW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
      end
      if (r_state == ST_CALC) begin
        rsp_sum              <= w_sum;
        rsp_flags[FLAG_COUT] <= w_cout;
        rsp_flags[FLAG_NEG]  <= w_neg;
        rsp_flags[FLAG_OVF]  <= w_ovf;
        rsp_flags[FLAG_ZERO] <= w_zero;
        rsp_id               <= r_id;
      end
    end
  end

`ifdef DPA_ARB_PERF_EN
  logic [NREQ-1:0][15:0] r_perf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (w_xfer && w_grant[i] && r_perf[i] != 16'hFFFF)
          r_perf[i] <= r_perf[i] + 16'd1;
      end
    end
  end

  assign perf_cnt = r_perf;
`endif

endmodule

// File: tb/tb_dpa_arb.sv
// tb_dpa_arb: directed self-checking bench for dpa_arb (N=64, NREQ=4).
// Inputs change 1 time unit after the rising edge; outputs are checked a
// further unit later, well away from the next edge.
module tb_dpa_arb;

  localparam int unsigned N    = 64;
  localparam int unsigned NREQ = 4;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
  logic [NREQ-1:0]   req_signed;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [N-1:0]      rsp_sum;
  logic [3:0]        rsp_flags;
`ifdef DPA_ARB_PERF_EN
  logic [NREQ*16-1:0] perf_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  dpa_arb #(.N(N), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .req_signed (req_signed),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_flags  (rsp_flags)
`ifdef DPA_ARB_PERF_EN
    ,
    .perf_cnt   (perf_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic sgn);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
    req_cin[i]      = cin;
    req_signed[i]   = sgn;
  endtask

  // Single requester, rsp_ready=1: accept, CALC, RESP, back to IDLE.
  task automatic single_op(input string tag, input int i,
                           input logic [63:0] a, input logic [63:0] b,
                           input logic cin, input logic sgn,
                           input logic [63:0] es, input logic [3:0] ef);
    set_req(i, a, b, cin, sgn);
    req_valid = 4'b0001 << i;
    rsp_ready = 1'b1;
    #1;
    chk({tag, ":ready"}, 64'(req_ready), 64'(4'b0001 << i));
    tick();                       // accept edge
    req_valid = '0;
    #1;
    chk({tag, ":calc_vld"}, 64'(rsp_valid), 64'd0);
    tick();                       // CALC -> RESP
    #1;
    chk({tag, ":vld"}, 64'(rsp_valid), 64'd1);
    chk({tag, ":id"}, 64'(rsp_id), 64'(i));
    chk({tag, ":sum"}, rsp_sum, es);
    chk({tag, ":flags"}, 64'(rsp_flags), 64'(ef));
    tick();                       // RESP -> IDLE
    #1;
    chk({tag, ":vld_fall"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '1;
    req_a      = '0;
    req_b      = '0;
    req_cin    = '0;
    req_signed = '0;
    rsp_ready  = 1'b0;

    // Reset state, including ready held low while requests are pending.
    tick();
    tick();
    #1;
    chk("rst:ready", 64'(req_ready), 64'd0);
    chk("rst:vld",   64'(rsp_valid), 64'd0);
    chk("rst:sum",   rsp_sum,        64'd0);
    chk("rst:flags", 64'(rsp_flags), 64'd0);
    chk("rst:id",    64'(rsp_id),    64'd0);
    req_valid = '0;
    rst       = 1'b0;
    tick();

    // rr_ptr walk: 0 -> 1, 2 -> 3, 1 (search 3,0,1) -> 2, 3 -> 0.
    single_op("add", 0, 64'd5, 64'd3, 1'b0, 1'b0, 64'd8, 4'b0000);
    single_op("sovf", 2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1,
              64'h8000_0000_0000_0000, 4'b0110);
    single_op("zero", 1, 64'd5, ~64'd5, 1'b1, 1'b0, 64'd0, 4'b1001);
    single_op("uovf", 3, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
              64'h8000_0000_0000_0000, 4'b0100);

    // Back-pressure: hold RESP for 5 cycles with everyone else requesting.
    set_req(0, '1, '1, 1'b0, 1'b1);
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    #1;
    chk("hold:ready", 64'(req_ready), 64'd1);
    tick();
    req_valid = '1;
    #1;
    chk("hold:calc_rdy", 64'(req_ready), 64'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold%0d:vld", k),   64'(rsp_valid), 64'd1);
      chk($sformatf("hold%0d:sum", k),   rsp_sum, 64'hFFFF_FFFF_FFFF_FFFE);
      chk($sformatf("hold%0d:flags", k), 64'(rsp_flags), 64'(4'b1100));
      chk($sformatf("hold%0d:id", k),    64'(rsp_id), 64'd0);
      chk($sformatf("hold%0d:rdy", k),   64'(req_ready), 64'd0);
      if (k < 4) tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("hold:idle_vld", 64'(rsp_valid), 64'd0);
    chk("hold:idle_rdy", 64'(req_ready), 64'(4'b0010));
    // Withdraw before the edge: nothing must be accepted.
    req_valid = '0;
    tick();
    #1;
    chk("withdraw:vld", 64'(rsp_valid), 64'd0);
    tick();
    chk("withdraw:vld2", 64'(rsp_valid), 64'd0);

    // Continuous requests from all four after reset: order 0,1,2,3,0,1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++)
      set_req(i, 64'(100 + i), 64'(i), 1'b0, 1'b0);
    req_valid = '1;
    rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("rr%0d:grant", k), 64'(req_ready), 64'(4'b0001 << (k % 4)));
      tick();
      chk($sformatf("rr%0d:calc", k), 64'(req_ready), 64'd0);
      tick();
      chk($sformatf("rr%0d:resp_rdy", k), 64'(req_ready), 64'd0);
      chk($sformatf("rr%0d:vld", k), 64'(rsp_valid), 64'd1);
      chk($sformatf("rr%0d:id", k),  64'(rsp_id), 64'(k % 4));
      chk($sformatf("rr%0d:sum", k), rsp_sum, 64'(100 + 2 * (k % 4)));
      tick();
    end

    // rr_ptr is now 2: accept requester 2, then reset during CALC.
    chk("rstcalc:grant", 64'(req_ready), 64'(4'b0100));
    tick();
    rst       = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
    #1;
    chk("rstcalc:vld0", 64'(rsp_valid), 64'd0);
    tick();
    chk("rstcalc:vld1", 64'(rsp_valid), 64'd0);
    tick();
    chk("rstcalc:vld2", 64'(rsp_valid), 64'd0);
    req_valid = '1;
    #1;
    chk("rstcalc:ptr0", 64'(req_ready), 64'd1);
`ifdef DPA_ARB_PERF_EN
    chk("rstcalc:perf", perf_cnt[63:0], 64'd0);
`endif
    req_valid = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
